ws2812_input_decoder: RTL and testbench
=======================================

Name: ws2812_input_decoder

Overview:
Decodes a single-wire WS2812 data stream back into bytes. It is the receiving end of the WS2812 output shifter and shares its timing.
- Measures each high pulse to decide 0/1.
- Assembles bits MSB-first into bytes.
- Reports frame boundaries when the line stays low for the reset time.
- Used for loopback self-test of the LED chain and for daisy-chained boards driven by a WS2812 master.

Parameters:
INPUT_CLOCK, 12_000_000, clk frequency in Hz; must not be much below 12 MHz.
All derived localparams use $rtoi(t * INPUT_CLOCK):
- TIME_THRESH: 575 ns; at 12 MHz = 6.
- TIME_HIGH_MAX: 5 us; at 12 MHz = 60.
- TIME_RESET: 50 us; at 12 MHz = 600.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
din  input  1  WS2812 serial line, asynchronous to clk.
data_out  output  8  last decoded byte; held until the next byte completes.
data_valid  output  1  one-cycle pulse; data_out is new this cycle.
frame_end  output  1  one-cycle pulse when a frame is closed by reset-low.
error  output  1  one-cycle pulse on a malformed stream.
busy  output  1  high while in HIGH or LOW state, i.e. inside a frame.

Behaviour:
Input path:
- din passes through a 2-flop synchronizer (reset to 0), then a registered copy for edge detection.
- All timing below refers to the synchronized signal s.

Reset:
- state=SYNC, all counters 0, shift register 0, bit count 0.
- data_out=0, data_valid=0, frame_end=0, error=0, busy=0.
- rst overrides everything in the same cycle, including mid-byte; the partial byte is discarded with no pulses.

Timer and counters:
- One timer, wide enough for TIME_RESET, saturating (no wrap).
- 3-bit bit counter and 8-bit shift register.

States:
- SYNC:
  - Count consecutive low cycles of s; any high clears the count.
  - When count reaches TIME_RESET, go to IDLE.
  - Highs in SYNC are never decoded.
- IDLE: on a rising edge of s, clear timer, go to HIGH.
- HIGH: count high cycles, including the first.
  - On a falling edge: bit = (count >= TIME_THRESH). Shift it into the LSB of the shift register, increment bit count, clear timer, go to LOW.
  - If count exceeds TIME_HIGH_MAX: pulse error, drop the partial byte, go to SYNC.
- LOW: count low cycles.
  - On a rising edge: clear timer, go to HIGH.
  - When count reaches TIME_RESET: pulse frame_end and go to IDLE. If bit count != 0 at that moment, also pulse error (same cycle) and discard the partial bits.
- Byte completion:
  - When the 8th bit is shifted in, load data_out and pulse data_valid one cycle after the falling edge is seen on s.
  - Bit count wraps to 0.
  - Total latency is 3 clk from the din falling edge to data_valid.
- No minimum low time is enforced; any low of at least 1 cycle separates bits.
- A byte completing and frame_end cannot coincide; TIME_RESET > 1.
- An illegal state value recovers to SYNC.

Test Plan:
- Reset, din low 600 cycles, then send 0xA5 (0 = 4 high/12 low, 1 = 10 high/7 low) -> exactly one data_valid pulse with data_out=0xA5, 3 cycles after the last falling edge. busy is high throughout the byte.
- Send 0x12, 0x34, 0x56 back-to-back, then hold low 600 cycles -> three data_valid pulses in order. A single frame_end pulse follows; error stays 0 and busy drops.
- Threshold boundary: high pulse of 5 cycles decodes 0, 6 cycles decodes 1. Check with bytes 0x00 and 0xFF built from these pulses.
- Send 3 bits (1,0,1), then low 600 -> frame_end and error pulse in the same cycle, no data_valid, and data_out keeps its previous value.
- Hold din high for 61 cycles mid-byte -> error pulse, state SYNC. Pulses sent with less than 600 low cycles before them are ignored; a byte after a 600-cycle low decodes correctly.
- Assert rst after 4 bits of 0xF0 -> all outputs 0 and no pulses. Bits sent within 600 low cycles after reset release are ignored; afterwards 0xF0 decodes correctly.

Source files
------------

// File: rtl/ws2812_input_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_input_decoder
// Description : Receives a single-wire WS2812 data stream and rebuilds the
//               bytes it carries. Each high pulse is measured to decide 0/1,
//               bits are assembled MSB-first, and a long low closes a frame.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1  clock
//   rst         in   1  synchronous, active-high reset
//   din         in   1  WS2812 serial line (asynchronous to clk)
//   data_out    out  8  last decoded byte, held until the next byte completes
//   data_valid  out  1  one-cycle pulse, data_out is new this cycle
//   frame_end   out  1  one-cycle pulse when a frame is closed by reset-low
//   error       out  1  one-cycle pulse on a malformed stream
//   busy        out  1  high while inside a frame (HIGH or LOW state)
// ============================================================================
module ws2812_input_decoder #(
  parameter int INPUT_CLOCK = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_end,
  output logic       error,
  output logic       busy
);

  // Integer form of $rtoi(t * INPUT_CLOCK). Floor division gives the same
  // result as truncation but cannot land one below an exact multiple the way
  // a binary floating-point product of 50e-6 can.
  localparam longint CLK_HZ        = longint'(INPUT_CLOCK);
  localparam int     TIME_THRESH   = int'((CLK_HZ * 575) / 1_000_000_000);
  localparam int     TIME_HIGH_MAX = int'((CLK_HZ * 5) / 1_000_000);
  localparam int     TIME_RESET    = int'((CLK_HZ * 50) / 1_000_000);
  localparam int     TW            = $clog2(TIME_RESET + 1);

  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] T_THRESH   = TW'(TIME_THRESH);
  localparam logic [TW-1:0] T_HIGH_MAX = TW'(TIME_HIGH_MAX);
  localparam logic [TW-1:0] T_RESET    = TW'(TIME_RESET);
  localparam logic [TW-1:0] T_SAT      = '1;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  // Input synchronizer plus a delayed copy for edge detection.
  logic sync1_q, s_q, s_prev_q;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_end_q, frame_end_d;
  logic          error_q, error_d;

  logic          w_rise, w_fall, w_bit;
  logic [TW-1:0] w_timer_inc;

  assign w_rise = s_q & ~s_prev_q;
  assign w_fall = ~s_q & s_prev_q;

  // Saturating increment so an endless low/high never wraps the timer.
  assign w_timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + T_ONE;

  // The timer already includes the current high cycle when the fall is seen.
  assign w_bit = (timer_q >= T_THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      s_prev_q     <= 1'b0;
      state_q      <= SYNC;
      timer_q      <= '0;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      sync1_q      <= din;
      s_q          <= sync1_q;
      s_prev_q     <= s_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_end_q  <= frame_end_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    error_d      = 1'b0;

    case (state_q)
      SYNC: begin
        // Wait for one full reset-low before trusting any pulse.
        if (s_q) begin
          timer_d = '0;
        end else if (w_timer_inc >= T_RESET) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = w_timer_inc;
        end
      end

      IDLE: begin
        if (w_rise) begin
          // The edge cycle is itself the first high cycle.
          timer_d = T_ONE;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (w_fall) begin
          shift_d  = {shift_q[6:0], w_bit};
          bitcnt_d = bitcnt_q + 3'd1;
          // The falling cycle is the first low cycle.
          timer_d  = T_ONE;
          state_d  = LOW;
          if (bitcnt_q == 3'd7) begin
            data_out_d   = {shift_q[6:0], w_bit};
            data_valid_d = 1'b1;
          end
        end else if (timer_q >= T_HIGH_MAX) begin
          // This cycle would push the high time past the maximum.
          error_d  = 1'b1;
          shift_d  = 8'h00;
          bitcnt_d = 3'd0;
          timer_d  = '0;
          state_d  = SYNC;
        end else begin
          timer_d = w_timer_inc;
        end
      end

      LOW: begin
        if (w_rise) begin
          timer_d = T_ONE;
          state_d = HIGH;
        end else if (w_timer_inc >= T_RESET) begin
          frame_end_d = 1'b1;
          error_d     = (bitcnt_q != 3'd0);
          shift_d     = 8'h00;
          bitcnt_d    = 3'd0;
          timer_d     = '0;
          state_d     = IDLE;
        end else begin
          timer_d = w_timer_inc;
        end
      end

      default: begin
        state_d  = SYNC;
        timer_d  = '0;
        shift_d  = 8'h00;
        bitcnt_d = 3'd0;
      end
    endcase
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_end  = frame_end_q;
  assign error      = error_q;
  assign busy       = (state_q == HIGH) || (state_q == LOW);

endmodule
`default_nettype wire

// File: tb/tb_ws2812_input_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_input_decoder
// Description : Self-checking bench for ws2812_input_decoder. Expected output
//               events (byte, frame end, error) are queued when stimulus is
//               driven and compared when the decoder pulses an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_input_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_end;
  logic       error;
  logic       busy;

  ws2812_input_decoder #(
    .INPUT_CLOCK(12_000_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_end (frame_end),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       dv;
    logic       fe;
    logic       er;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  ev_t q[$];

  typedef struct {
    logic [7:0] tx;
    int         h0;
    int         l0;
    int         h1;
    int         l1;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  int         last_fall = 0;
  logic [7:0] exp_last  = 8'h00;

  // Scoreboard: every output pulse must match the head of the queue.
  always @(negedge clk) begin : mon
    ev_t e;
    if (data_valid || frame_end || error) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: dv=%0b fe=%0b err=%0b data=%02h at cyc %0d, required no event",
                 data_valid, frame_end, error, data_out, cyc);
      end else begin
        e = q.pop_front();
        if ({data_valid, frame_end, error} !== {e.dv, e.fe, e.er} ||
            (e.dv && data_out !== e.data) || cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL event: got dv/fe/err=%b%b%b data=%02h cyc=%0d, required %b%b%b data=%02h cyc %0d..%0d",
                   data_valid, frame_end, error, data_out, cyc, e.dv, e.fe, e.er, e.data, e.lo, e.hi);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic push(input logic dv, input logic fe, input logic er,
                      input logic [7:0] data, input int lo, input int hi);
    ev_t e;
    e.dv = dv; e.fe = fe; e.er = er; e.data = data; e.lo = lo; e.hi = hi;
    q.push_back(e);
    if (dv) exp_last = data;
  endtask

  // Send the top n bits of b MSB-first. When decode is set the decoder is
  // expected to be inside a frame, so a full byte must come out 3 clk after
  // the last din fall and busy must be high mid-byte; otherwise busy is low.
  task automatic send_bits(input logic [7:0] b, input int n,
                           input int h0, input int l0, input int h1, input int l1,
                           input bit decode, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      logic bv;
      bv = b[7-i];
      din = 1'b1;
      tick(bv ? h1 : h0);
      din = 1'b0;
      last_fall = cyc;
      if (n == 8 && i == 7 && decode) push(1'b1, 1'b0, 1'b0, exp, cyc + 3, cyc + 3);
      if (i == 3) chk("busy_mid_byte", {31'd0, busy}, {31'd0, decode});
      tick(bv ? l1 : l0);
    end
  endtask

  // Hold the line low; a frame close lands about 600 low cycles plus the
  // synchronizer delay after the last fall.
  task automatic idle_low(input int n, input bit fe, input bit er);
    din = 1'b0;
    if (fe) push(1'b0, 1'b1, er, 8'h00, last_fall + 598, last_fall + 606);
    tick(n);
  endtask

  initial begin
    vecs[0] = '{tx: 8'hA5, h0: 4, l0: 12, h1: 10, l1: 7, exp: 8'hA5};
    vecs[1] = '{tx: 8'h12, h0: 4, l0: 12, h1: 10, l1: 7, exp: 8'h12};
    vecs[2] = '{tx: 8'h34, h0: 4, l0: 12, h1: 10, l1: 7, exp: 8'h34};
    vecs[3] = '{tx: 8'h56, h0: 4, l0: 12, h1: 10, l1: 7, exp: 8'h56};
    vecs[4] = '{tx: 8'h00, h0: 5, l0: 12, h1: 6,  l1: 7, exp: 8'h00};
    vecs[5] = '{tx: 8'hFF, h0: 5, l0: 12, h1: 6,  l1: 7, exp: 8'hFF};
    vecs[6] = '{tx: 8'hFF, h0: 5, l0: 12, h1: 5,  l1: 7, exp: 8'h00};
    vecs[7] = '{tx: 8'h00, h0: 6, l0: 12, h1: 6,  l1: 7, exp: 8'hFF};

    // Reset state.
    rst = 1'b1;
    din = 1'b0;
    tick(3);
    chk("reset_data_out",   {24'd0, data_out}, 32'h00);
    chk("reset_data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset_frame_end",  {31'd0, frame_end}, 32'd0);
    chk("reset_error",      {31'd0, error}, 32'd0);
    chk("reset_busy",       {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(620);

    // Normal bytes and threshold boundary, all inside one frame.
    for (int i = 0; i < 8; i++) begin
      send_bits(vecs[i].tx, 8, vecs[i].h0, vecs[i].l0, vecs[i].h1, vecs[i].l1,
                1'b1, vecs[i].exp);
    end
    idle_low(620, 1'b1, 1'b0);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    chk("data_out_after_frame", {24'd0, data_out}, {24'd0, exp_last});

    // Partial byte closed by reset-low: frame_end and error together.
    send_bits(8'b1010_0000, 3, 4, 12, 10, 7, 1'b1, 8'h00);
    idle_low(620, 1'b1, 1'b1);
    chk("data_out_kept_after_partial", {24'd0, data_out}, {24'd0, exp_last});
    chk("busy_after_partial", {31'd0, busy}, 32'd0);

    // Over-long high mid-byte.
    send_bits(8'b1100_0000, 3, 4, 12, 10, 7, 1'b1, 8'h00);
    din = 1'b1;
    push(1'b0, 1'b0, 1'b1, 8'h00, cyc + 60, cyc + 66);
    tick(61);
    din = 1'b0;
    tick(10);
    chk("busy_after_long_high", {31'd0, busy}, 32'd0);
    tick(90);
    send_bits(8'h5A, 8, 4, 12, 10, 7, 1'b0, 8'h00);
    tick(620);
    send_bits(8'h3C, 8, 4, 12, 10, 7, 1'b1, 8'h3C);

    // Reset in the middle of a byte.
    send_bits(8'hF0, 4, 4, 12, 10, 7, 1'b1, 8'h00);
    rst = 1'b1;
    tick(2);
    chk("midbyte_rst_data_out", {24'd0, data_out}, 32'h00);
    chk("midbyte_rst_busy",     {31'd0, busy}, 32'd0);
    chk("midbyte_rst_valid",    {31'd0, data_valid}, 32'd0);
    rst = 1'b0;
    exp_last = 8'h00;
    send_bits(8'hF0, 8, 4, 12, 10, 7, 1'b0, 8'h00);
    chk("data_out_after_ignored", {24'd0, data_out}, 32'h00);
    tick(620);
    send_bits(8'hF0, 8, 4, 12, 10, 7, 1'b1, 8'hF0);
    idle_low(620, 1'b1, 1'b0);
    tick(20);

    chk("events_outstanding", q.size(), 32'd0);
    chk("final_data_out", {24'd0, data_out}, 32'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
